coverfloat_vector_sequencer: RTL

- Sequences test vectors from a vector memory into the coverage/check path, one vector per valid handshake.
- Sits between a synchronous vector ROM/RAM and the coverfloat interface; its out_valid drives the interface valid that triggers check() and sample().
- Controls vector pacing with a programmable inter-vector gap, terminates on a last-flag or vector limit, and reports progress.

---
 rtl/coverfloat_vector_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/coverfloat_vector_sequencer.sv
// coverfloat_vector_sequencer: paces vectors from a synchronous memory into the coverfloat valid/ready interface.
// Optional watchdog on a stalled consumer is enabled by defining CF_SEQ_TIMEOUT_EN.
module coverfloat_vector_sequencer #(
    parameter int VEC_W   = 256,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_vecs,
    input  logic [7:0]        gap_cycles,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [VEC_W-1:0]  mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VEC_W-1:0]  out_vec,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   vec_count,
    output logic              timeout
);
    localparam int LAT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PRESENT, GAP, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   num_q, vec_count_q;
    logic [7:0]        gap_q, gap_cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [VEC_W-1:0]  out_vec_q;
    logic [LAT_W-1:0]  lat_q;
    logic              start_ok, lat_done, hs, last, wd_fire;

    assign start_ok  = start && !abort && !busy;
    assign lat_done  = lat_q == LAT_W'(MEM_LAT - 1);
    assign hs        = state_q == PRESENT && out_ready && !abort;
    assign last      = out_vec_q[VEC_W-1] || (vec_count_q + 1'b1 == num_q);
    assign mem_addr  = mem_addr_q;
    assign out_vec   = out_vec_q;
    assign vec_count = vec_count_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (busy && abort) state_d = IDLE;
        else begin
            case (state_q)
                IDLE, DONE: if (start_ok) state_d = num_vecs == '0 ? DONE : FETCH;
                FETCH:      state_d = WAIT;
                WAIT:       if (lat_done) state_d = PRESENT;
                PRESENT:    if (wd_fire) state_d = DONE;
                            else if (hs) state_d = last ? DONE : gap_q != '0 ? GAP : FETCH;
                GAP:        if (gap_cnt_q == 8'd1) state_d = FETCH;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd_en = state_q == FETCH;
        out_valid = state_q == PRESENT;
        busy      = state_q != IDLE && state_q != DONE;
        done      = state_q == DONE;
    end

    // Read data is captured only on the final WAIT cycle; an abort there discards it.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            vec_count_q <= '0;
            mem_addr_q  <= '0;
            out_vec_q   <= '0;
            lat_q       <= '0;
        end else begin
            if (start_ok) begin
                num_q       <= num_vecs;
                gap_q       <= gap_cycles;
                vec_count_q <= '0;
                mem_addr_q  <= '0;
            end
            if (state_q == FETCH) lat_q <= '0;
            if (state_q == WAIT && !abort) begin
                if (lat_done) out_vec_q <= mem_rd_data;
                else          lat_q     <= lat_q + 1'b1;
            end
            if (hs) begin
                vec_count_q <= vec_count_q + 1'b1;
                gap_cnt_q   <= gap_q;
                if (!last) mem_addr_q <= mem_addr_q + 1'b1;
            end
            if (state_q == GAP) gap_cnt_q <= gap_cnt_q - 1'b1;
        end
    end

`ifdef CF_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q;
    logic            timeout_q;

    assign wd_fire = state_q == PRESENT && !out_ready && !abort && wd_q == WD_W'(TIMEOUT - 1);
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= (state_q == PRESENT && !out_ready) ? wd_q + 1'b1 : '0;
            if (start_ok)     timeout_q <= 1'b0;
            else if (wd_fire) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign wd_fire        = 1'b0;
    assign timeout        = 1'b0;
    assign unused_timeout = |TIMEOUT;
`endif
endmodule
